// File: rtl/gmii_udp_frame_gen.sv
// GMII-side UDP/IPv4 frame generator. Emits preamble, SFD, headers, a patterned payload, pad and FCS
// one byte per clock, and supports bursts, continuous mode and a configurable inter-frame gap.
module gmii_udp_frame_gen #(
    parameter logic [47:0] SRC_MAC     = 48'h11_11_11_11_11_11,
    parameter logic [47:0] DEST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP      = 32'hC0_A8_01_69,
    parameter logic [31:0] DEST_IP     = 32'hC0_A8_01_6E,
    parameter logic [15:0] SRC_PORT    = 16'h8080,
    parameter logic [15:0] DEST_PORT   = 16'h8080,
    parameter int          MAX_PAYLOAD = 1472,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  num_frames,
    input  logic [15:0] payload_len,
    input  logic [7:0]  seed,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent
);

    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_PRE, S_SFD, S_ETH, S_IP, S_UDP,
        S_PAY, S_PAD, S_FCS, S_IFG, S_DONE
    } state_t;

    state_t      state, next_state;
    logic [15:0] cnt;
    logic [15:0] pay_len;
    logic [7:0]  seed_l;
    logic [7:0]  nframes_l;
    logic [7:0]  frame_cnt;
    logic        stop_pending;
    logic [15:0] ident;
    logic [15:0] csum;
    logic [31:0] crc;

    logic [15:0]  pad_len, tot_len, udp_len;
    logic [31:0]  csum_sum, csum_fold1, csum_fold2;
    logic [111:0] eth_hdr, eth_sh;
    logic [159:0] ip_hdr, ip_sh;
    logic [63:0]  udp_hdr, udp_sh;
    logic [31:0]  fcs_sh;
    logic [7:0]   tx_byte;
    logic         tx_active, crc_en, burst_over, last_fcs;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    assign pad_len    = (pay_len < 16'd18) ? (16'd18 - pay_len) : 16'd0;
    assign tot_len    = pay_len + 16'd28;
    assign udp_len    = pay_len + 16'd8;
    assign burst_over = stop_pending || ((nframes_l != 8'd0) && (frame_cnt == nframes_l));
    assign last_fcs   = (state == S_FCS) && (cnt == 16'd3);
    assign tx_active  = (state inside {S_PRE, S_SFD, S_ETH, S_IP, S_UDP, S_PAY, S_PAD, S_FCS});
    assign crc_en     = (state inside {S_ETH, S_IP, S_UDP, S_PAY, S_PAD});

    // Header checksum with the checksum field as zero; two folds absorb every end-around carry.
    always_comb begin
        csum_sum   = 32'h4500 + 32'(tot_len) + 32'(ident) + 32'h4000 + 32'h4011
                   + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
                   + 32'(DEST_IP[31:16]) + 32'(DEST_IP[15:0]);
        csum_fold1 = {16'h0, csum_sum[15:0]} + {16'h0, csum_sum[31:16]};
        csum_fold2 = {16'h0, csum_fold1[15:0]} + {16'h0, csum_fold1[31:16]};
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_CALC;
            S_CALC: next_state = S_PRE;
            S_PRE:  if (cnt == 16'd6) next_state = S_SFD;
            S_SFD:  next_state = S_ETH;
            S_ETH:  if (cnt == 16'd13) next_state = S_IP;
            S_IP:   if (cnt == 16'd19) next_state = S_UDP;
            S_UDP:
                if (cnt == 16'd7)
                    next_state = (pay_len != 16'd0) ? S_PAY : ((pad_len != 16'd0) ? S_PAD : S_FCS);
            S_PAY:
                if (cnt == pay_len - 16'd1)
                    next_state = (pad_len != 16'd0) ? S_PAD : S_FCS;
            S_PAD:  if (cnt == pad_len - 16'd1) next_state = S_FCS;
            S_FCS:  if (cnt == 16'd3) next_state = S_IFG;
            S_IFG:  if (cnt == IFG_LAST) next_state = burst_over ? S_DONE : S_CALC;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        eth_hdr = {DEST_MAC, SRC_MAC, 16'h0800};
        ip_hdr  = {16'h4500, tot_len, ident, 16'h4000, 8'h40, 8'h11, csum, SRC_IP, DEST_IP};
        udp_hdr = {SRC_PORT, DEST_PORT, udp_len, 16'h0000};
        eth_sh  = eth_hdr << {cnt[3:0], 3'b000};
        ip_sh   = ip_hdr << {cnt[4:0], 3'b000};
        udp_sh  = udp_hdr << {cnt[2:0], 3'b000};
        fcs_sh  = ~crc >> {cnt[1:0], 3'b000};
        tx_byte = 8'h00;
        case (state)
            S_PRE:   tx_byte = 8'h55;
            S_SFD:   tx_byte = 8'hD5;
            S_ETH:   tx_byte = eth_sh[111:104];
            S_IP:    tx_byte = ip_sh[159:152];
            S_UDP:   tx_byte = udp_sh[63:56];
            S_PAY:   tx_byte = seed_l + cnt[7:0];
            S_FCS:   tx_byte = fcs_sh[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge rgmii_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? 16'd0 : cnt + 16'd1;
        end
    end

    // Outputs are registered from the current state, so the wire lags the FSM by one cycle.
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            gmii_tx_en   <= 1'b0;
            gmii_txd     <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            frames_sent  <= 32'd0;
            pay_len      <= 16'd0;
            seed_l       <= 8'h00;
            nframes_l    <= 8'd0;
            frame_cnt    <= 8'd0;
            stop_pending <= 1'b0;
            ident        <= 16'd0;
            csum         <= 16'd0;
            crc          <= 32'hFFFF_FFFF;
        end else begin
            gmii_tx_en <= tx_active;
            gmii_txd   <= tx_byte;
            done       <= (state == S_DONE);

            if (state == S_IDLE) begin
                stop_pending <= 1'b0;
                if (start) begin
                    pay_len   <= (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
                    seed_l    <= seed;
                    nframes_l <= num_frames;
                    frame_cnt <= 8'd0;
                    busy      <= 1'b1;
                end
            end else if (stop) begin
                stop_pending <= 1'b1;
            end

            if (state == S_CALC) begin
                csum <= ~csum_fold2[15:0];
                crc  <= 32'hFFFF_FFFF;
            end else if (crc_en) begin
                crc <= crc32_byte(crc, tx_byte);
            end

            if (last_fcs) begin
                frames_sent <= frames_sent + 32'd1;
                ident       <= ident + 16'd1;
                frame_cnt   <= frame_cnt + 8'd1;
            end

            if (state == S_DONE) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gmii_udp_frame_gen.sv
// Self-checking bench for gmii_udp_frame_gen: table-driven single frames, burst/continuous/reset
// sequences, and randomized bursts compared against a byte-list frame model.
module tb_gmii_udp_frame_gen;

    localparam int IFG     = 12;
    localparam int MAX_PAY = 1472;

    typedef struct {
        int         len;
        logic [7:0] sd;
        int         fr_len;
        int         totlen;
        int         udplen;
        int         csum;
    } vec_t;

    logic        rgmii_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  num_frames = 8'd0;
    logic [15:0] payload_len = 16'd0;
    logic [7:0]  seed = 8'd0;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    gmii_udp_frame_gen dut (
        .rgmii_clk   (rgmii_clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .num_frames  (num_frames),
        .payload_len (payload_len),
        .seed        (seed),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #4 rgmii_clk = ~rgmii_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor log, sampled on the falling edge.
    int         cycle = 0;
    logic       prev_en = 1'b0;
    logic [7:0] cap[$];
    int         f_off[$];
    int         f_len[$];
    int         f_start[$];
    int         f_end[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         done_busy = 0;
    int         start_cyc = 0;
    int         idle_dirty = 0;
    logic [7:0] exp_q[$];

    initial forever begin
        @(negedge rgmii_clk);
        cycle++;
        if (start && !busy) start_cyc = cycle;
        if (gmii_tx_en) begin
            if (!prev_en) begin
                f_off.push_back(cap.size());
                f_start.push_back(cycle);
            end
            cap.push_back(gmii_txd);
        end else begin
            if (prev_en) begin
                f_len.push_back(cap.size() - f_off[$]);
                f_end.push_back(cycle - 1);
            end
            if (gmii_txd != 8'h00) idle_dirty++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cycle;
            if (busy) done_busy++;
        end
        prev_en = gmii_tx_en;
    end

    initial begin
        #720000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rgmii_clk);
        #1;
    endtask

    task automatic clear_log();
        cap.delete(); f_off.delete(); f_len.delete(); f_start.delete(); f_end.delete();
        done_cnt = 0; done_busy = 0; idle_dirty = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(1);
        clear_log();
    endtask

    task automatic launch(input int nf, input int len, input logic [7:0] sd);
        num_frames  = 8'(nf);
        payload_len = 16'(len);
        seed        = sd;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin tick(1); k++; end
        check({name, " done seen"}, int'(done_cnt > 0), 1);
        tick(2);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic [7:0]  dd;
        c  = c_in;
        dd = d;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ dd[0]) c = (c >> 1) ^ 32'hEDB8_8320;
            else              c = c >> 1;
            dd = dd >> 1;
        end
        return c;
    endfunction

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(8'(v >> (8 * i)));
    endtask

    // Reference frame: list of bytes built straight from the field layout.
    task automatic build_expected(input int len, input logic [7:0] sd, input int ident);
        int          l, p, sum;
        int          w[10];
        logic [31:0] c;
        l = (len > MAX_PAY) ? MAX_PAY : len;
        p = (l < 18) ? 18 - l : 0;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(64'hFFFF_FFFF_FFFF, 6);
        push_be(64'h1111_1111_1111, 6);
        push_be(64'h0800, 2);
        w = '{'h4500, 28 + l, ident & 'hFFFF, 'h4000, 'h4011, 0, 'hC0A8, 'h0169, 'hC0A8, 'h016E};
        sum = 0;
        foreach (w[i]) sum += w[i];
        while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
        w[5] = (~sum) & 'hFFFF;
        foreach (w[i]) push_be(64'(w[i]), 2);
        push_be(64'h8080, 2);
        push_be(64'h8080, 2);
        push_be(64'(8 + l), 2);
        push_be(64'h0000, 2);
        for (int i = 0; i < l; i++) exp_q.push_back(8'((int'(sd) + i) % 256));
        repeat (p) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
    endtask

    function automatic int cap16(input int idx, input int o);
        return int'({cap[f_off[idx] + o], cap[f_off[idx] + o + 1]});
    endfunction

    task automatic compare_frame(input int idx, input int len, input logic [7:0] sd,
                                 input int ident, input string name);
        int          off, n, mism;
        logic [31:0] r, rev;
        build_expected(len, sd, ident);
        check({name, " present"}, int'(f_len.size() > idx), 1);
        if (f_len.size() <= idx) return;
        off = f_off[idx];
        n   = f_len[idx];
        check({name, " length"}, n, exp_q.size());
        mism = 0;
        for (int k = 0; k < n && k < exp_q.size(); k++)
            if (cap[off + k] !== exp_q[k]) mism++;
        check({name, " byte mismatches"}, mism, 0);
        if (n > 12) begin
            r = 32'hFFFF_FFFF;
            for (int k = 8; k < n; k++) r = crc_upd(r, cap[off + k]);
            rev = 32'h0;
            for (int k = 0; k < 32; k++) begin rev = {rev[30:0], r[0]}; r = r >> 1; end
            check({name, " crc residue"}, int'(rev), int'(32'hC704_DD7B));
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   total, id_base, k, zeros;

        vecs[0] = '{32,   8'h00, 86,   'h003C, 'h0028, 'hB689};
        vecs[1] = '{4,    8'h55, 72,   'h0020, 'h000C, 'hB6A5};
        vecs[2] = '{0,    8'hAA, 72,   'h001C, 'h0008, 'hB6A9};
        vecs[3] = '{17,   8'h01, 72,   'h002D, 'h0019, 'hB698};
        vecs[4] = '{18,   8'hFE, 72,   'h002E, 'h001A, 'hB697};
        vecs[5] = '{2000, 8'hF0, 1526, 'h05DC, 'h05C8, 'hB0E9};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            if (v == 0) begin
                check("reset tx_en", int'(gmii_tx_en), 0);
                check("reset txd", int'(gmii_txd), 0);
                check("reset busy", int'(busy), 0);
                check("reset done", int'(done), 0);
                check("reset frames_sent", int'(frames_sent), 0);
            end
            launch(1, vecs[v].len, vecs[v].sd);
            check($sformatf("vec%0d busy after start", v), int'(busy), 1);
            wait_done(3000, $sformatf("vec%0d", v));
            check($sformatf("vec%0d frame count", v), f_len.size(), 1);
            check($sformatf("vec%0d frames_sent", v), int'(frames_sent), 1);
            check($sformatf("vec%0d done pulses", v), done_cnt, 1);
            check($sformatf("vec%0d busy at done", v), done_busy, 0);
            check($sformatf("vec%0d idle txd", v), idle_dirty, 0);
            if (f_len.size() > 0 && f_len[0] >= 54) begin
                check($sformatf("vec%0d tx_en cycles", v), f_len[0], vecs[v].fr_len);
                check($sformatf("vec%0d start latency", v), f_start[0] - start_cyc, 3);
                check($sformatf("vec%0d done after ifg", v), done_cyc - f_end[0], IFG + 1);
                check($sformatf("vec%0d totlen", v), cap16(0, 24), vecs[v].totlen);
                check($sformatf("vec%0d udp len", v), cap16(0, 46), vecs[v].udplen);
                check($sformatf("vec%0d ip csum", v), cap16(0, 32), vecs[v].csum);
                check($sformatf("vec%0d ident", v), cap16(0, 26), 0);
            end
            compare_frame(0, vecs[v].len, vecs[v].sd, 0, $sformatf("vec%0d", v));
            if (vecs[v].len == 4 && f_len.size() > 0 && f_len[0] >= 72) begin
                zeros = 0;
                for (int i = 54; i < 68; i++) if (cap[f_off[0] + i] == 8'h00) zeros++;
                check("pad zero bytes", zeros, 14);
            end
            if (vecs[v].len == 2000 && f_len.size() > 0 && f_len[0] >= 100) begin
                check("wrap byte 15", int'(cap[f_off[0] + 65]), 'hFF);
                check("wrap byte 16", int'(cap[f_off[0] + 66]), 'h00);
            end
        end

        // Burst of three frames: fixed spacing and incrementing ident.
        do_reset();
        launch(3, 20, 8'h80);
        wait_done(3000, "burst");
        check("burst frames", f_len.size(), 3);
        check("burst frames_sent", int'(frames_sent), 3);
        check("burst done pulses", done_cnt, 1);
        for (int i = 0; i < 2 && i + 1 < f_start.size(); i++)
            check($sformatf("burst gap %0d", i), f_start[i + 1] - f_end[i] - 1, IFG + 1);
        for (int i = 0; i < 3; i++) begin
            compare_frame(i, 20, 8'h80, i, $sformatf("burst f%0d", i));
            if (f_len.size() > i) check($sformatf("burst ident %0d", i), cap16(i, 26), i);
        end

        // Continuous mode, stop during frame 5, start while busy.
        do_reset();
        launch(0, 10, 8'h33);
        k = 0;
        while (f_start.size() < 5 && k < 3000) begin tick(1); k++; end
        check("cont reached frame 5", int'(f_start.size() >= 5), 1);
        tick(20);
        payload_len = 16'd50;
        seed        = 8'h99;
        stop        = 1'b1;
        start       = 1'b1;
        tick(1);
        stop        = 1'b0;
        start       = 1'b0;
        wait_done(2000, "cont");
        check("cont frames", f_len.size(), 5);
        check("cont frames_sent", int'(frames_sent), 5);
        for (int i = 0; i < 5; i++) compare_frame(i, 10, 8'h33, i, $sformatf("cont f%0d", i));
        if (f_end.size() == 5) check("cont done after ifg", done_cyc - f_end[4], IFG + 1);
        tick(60);
        check("cont no frame 6", f_start.size(), 5);
        check("cont single done", done_cnt, 1);
        check("cont idle busy", int'(busy), 0);

        // stop alone in IDLE, then stop together with start: both discarded.
        do_reset();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        check("idle stop no busy", int'(busy), 0);
        stop = 1'b1;
        launch(2, 6, 8'h07);
        stop = 1'b0;
        wait_done(2000, "start+stop");
        check("start+stop frames", f_len.size(), 2);
        check("start+stop frames_sent", int'(frames_sent), 2);

        // Randomized bursts against the model.
        do_reset();
        total   = 0;
        id_base = 0;
        for (int it = 0; it < 8; it++) begin
            int         len, nf;
            logic [7:0] sd;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1400, 2100))
                                              : int'($urandom_range(0, 300));
            nf  = int'($urandom_range(1, 3));
            sd  = 8'($urandom);
            clear_log();
            launch(nf, len, sd);
            wait_done(nf * 1600 + 200, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d frames", it), f_len.size(), nf);
            for (int f = 0; f < nf; f++)
                compare_frame(f, len, sd, id_base + f, $sformatf("rnd%0d f%0d", it, f));
            id_base += nf;
            total   += nf;
            check($sformatf("rnd%0d frames_sent", it), int'(frames_sent), total);
            check($sformatf("rnd%0d done pulses", it), done_cnt, 1);
        end

        // Reset during the payload, then a clean frame with ident 0.
        clear_log();
        launch(1, 200, 8'h10);
        k = 0;
        while (cap.size() < 70 && k < 500) begin tick(1); k++; end
        check("midreset reached payload", int'(cap.size() >= 70), 1);
        rst = 1'b1;
        tick(1);
        check("midreset tx_en", int'(gmii_tx_en), 0);
        check("midreset txd", int'(gmii_txd), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset frames_sent", int'(frames_sent), 0);
        rst = 1'b0;
        tick(2);
        clear_log();
        launch(1, 32, 8'h00);
        wait_done(2000, "post reset");
        compare_frame(0, 32, 8'h00, 0, "post reset");
        check("post reset frames_sent", int'(frames_sent), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
